// File: rtl/corr_argmax_pkg.sv
// Shared sizing constants for the correlation arg-max search.
package corr_argmax_pkg;

  localparam int unsigned VMU_DATA_WIDTH = 16;
  localparam int unsigned DEF_COL_NUM    = 256;
  localparam int unsigned DEF_IDX_WIDTH  = 8;

endpackage

// File: rtl/abs_sat.sv
// Saturating magnitude of a two's-complement word; the most-negative code maps to max positive.
module abs_sat
  import corr_argmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = VMU_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  always_comb begin
    q = d;
    if (d == MOST_NEG) begin
      q = MOST_POS;
    end else if (d[DATA_WIDTH-1]) begin
      q = (~d) + DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/corr_argmax.sv
// Scans COL_NUM correlation beats, picks the largest magnitude among columns not yet selected,
// and marks the winner in a selection bitmap so later scans skip it.
module corr_argmax
  import corr_argmax_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = VMU_DATA_WIDTH,
  parameter int unsigned COL_NUM    = DEF_COL_NUM,
  parameter int unsigned IDX_WIDTH  = DEF_IDX_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clr_sel,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic [IDX_WIDTH-1:0]         max_idx,
  output logic [DATA_WIDTH-1:0]        max_abs,
  output logic [IDX_WIDTH:0]           sel_cnt,
  output logic                         err
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  localparam int unsigned CW = IDX_WIDTH + 1;

  state_t                state, state_nxt;
  logic [IDX_WIDTH-1:0]  beat_idx;
  logic [COL_NUM-1:0]    bitmap;

  logic                  accept_c, last_c, start_ok_c, clr_ok_c;
  logic [DATA_WIDTH-1:0] abs_c;

  logic                  s1_vld, s1_excl;
  logic [DATA_WIDTH-1:0] s1_abs;
  logic [IDX_WIDTH-1:0]  s1_idx;

  logic                  best_vld;
  logic [DATA_WIDTH-1:0] best_abs;
  logic [IDX_WIDTH-1:0]  best_idx;

  logic                  take_c, nb_vld_c;
  logic [DATA_WIDTH-1:0] nb_abs_c;
  logic [IDX_WIDTH-1:0]  nb_idx_c;

  abs_sat #(.DATA_WIDTH(DATA_WIDTH)) u_abs_sat (
    .d (in_data),
    .q (abs_c)
  );

  assign accept_c   = (state == SCAN) && in_valid;
  assign last_c     = accept_c && (beat_idx == IDX_WIDTH'(COL_NUM - 1));
  assign start_ok_c = (state == IDLE) && start;
  assign clr_ok_c   = (state == IDLE) && clr_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last_c) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage-2 merge: strictly greater wins, so equal magnitudes keep the earlier column.
  always_comb begin
    take_c   = s1_vld && !s1_excl && (!best_vld || (s1_abs > best_abs));
    nb_vld_c = best_vld || take_c;
    nb_abs_c = take_c ? s1_abs : best_abs;
    nb_idx_c = take_c ? s1_idx : best_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx <= '0;
      s1_vld   <= 1'b0;
      s1_excl  <= 1'b0;
      s1_abs   <= '0;
      s1_idx   <= '0;
      best_vld <= 1'b0;
      best_abs <= '0;
      best_idx <= '0;
    end else begin
      s1_vld <= accept_c;
      if (accept_c) begin
        s1_abs  <= abs_c;
        s1_idx  <= beat_idx;
        s1_excl <= bitmap[beat_idx];
      end
      if (start_ok_c) begin
        beat_idx <= '0;
        best_vld <= 1'b0;
        best_abs <= '0;
        best_idx <= '0;
      end else begin
        if (accept_c) beat_idx <= beat_idx + IDX_WIDTH'(1);
        best_vld <= nb_vld_c;
        best_abs <= nb_abs_c;
        best_idx <= nb_idx_c;
      end
    end
  end

  // Result and selection bookkeeping are committed on the FLUSH->DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      found   <= 1'b0;
      max_idx <= '0;
      max_abs <= '0;
      sel_cnt <= '0;
      bitmap  <= '0;
      err     <= 1'b0;
    end else begin
      busy <= (state_nxt == SCAN) || (state_nxt == FLUSH);
      done <= (state == FLUSH);
      if (state == FLUSH) begin
        found   <= nb_vld_c;
        max_idx <= nb_vld_c ? nb_idx_c : '0;
        max_abs <= nb_vld_c ? nb_abs_c : '0;
        if (nb_vld_c) begin
          bitmap[nb_idx_c] <= 1'b1;
          if (sel_cnt != CW'(COL_NUM)) sel_cnt <= sel_cnt + CW'(1);
        end
      end else if (clr_ok_c) begin
        bitmap  <= '0;
        sel_cnt <= '0;
      end
      if (start_ok_c) err <= 1'b0;
      if (in_valid && (state != SCAN)) err <= 1'b1;
    end
  end

endmodule
